// File: rtl/turn_seq.sv
// Tail-light turn/hazard sequencer: synchronised switch requests drive a
// prescaled mode FSM, thermometer lamp banks and a status digit.
// Optional macro TURN_SEQ_HEX_STATUS_EN enables the HEX0 mode decode (else blank).
module turn_seq #(
  parameter int LAMPS = 3,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             Rn,
  input  logic [1:0]       SW,
  input  logic             hazard,
  output logic [2:0]       CurrentState,
  output logic [LAMPS-1:0] LEDR_L,
  output logic [LAMPS-1:0] LEDR_R,
  output logic [7:0]       HEX0
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW_W = $clog2(LAMPS + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEFT  = 3'd1,
    S_RIGHT = 3'd2,
    S_HAZ   = 3'd3
  } state_t;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_LEFT  = 2'd1,
    REQ_RIGHT = 2'd2,
    REQ_HAZ   = 2'd3
  } req_t;

  logic [1:0]       sw_s1, sw_s2;
  logic             hz_s1, hz_s2;
  logic [CW-1:0]    cnt;
  logic             tick;
  state_t           state, state_n;
  logic [SW_W-1:0]  step, step_n;
  logic             ph, ph_n;
  logic [LAMPS-1:0] led_l, led_r, led_l_n, led_r_n;
  req_t             req;

  function automatic logic [LAMPS-1:0] therm(input logic [SW_W-1:0] n);
    logic [LAMPS-1:0] t;
    t = '0;
    for (int i = 0; i < LAMPS; i++) begin
      if (i < int'(n)) t[i] = 1'b1;
    end
    return t;
  endfunction

  function automatic state_t mode_of(input req_t r);
    state_t m;
    case (r)
      REQ_LEFT:  m = S_LEFT;
      REQ_RIGHT: m = S_RIGHT;
      REQ_HAZ:   m = S_HAZ;
      default:   m = S_IDLE;
    endcase
    return m;
  endfunction

  // Both sides at once is treated as a hazard request.
  always_comb begin
    req = REQ_NONE;
    if (hz_s2 || (sw_s2[0] && sw_s2[1])) req = REQ_HAZ;
    else if (sw_s2[0])                   req = REQ_LEFT;
    else if (sw_s2[1])                   req = REQ_RIGHT;
  end

  assign tick = (cnt == CW'(DIV - 1));

  // Transitions only on tick; a turn sweep runs to completion unless hazard preempts.
  always_comb begin
    state_n = state;
    step_n  = step;
    ph_n    = ph;
    if (tick) begin
      case (state)
        S_IDLE: begin
          if (req != REQ_NONE) begin
            state_n = mode_of(req);
            step_n  = '0;
            ph_n    = 1'b0;
          end
        end
        S_LEFT, S_RIGHT: begin
          if (req == REQ_HAZ) begin
            state_n = S_HAZ;
            step_n  = '0;
            ph_n    = 1'b0;
          end else if (step == SW_W'(LAMPS)) begin
            state_n = mode_of(req);
            step_n  = '0;
          end else begin
            step_n  = step + SW_W'(1);
          end
        end
        S_HAZ: begin
          if (req == REQ_HAZ) begin
            ph_n = ~ph;
          end else if (ph) begin
            ph_n = 1'b0;
          end else begin
            state_n = mode_of(req);
            step_n  = '0;
          end
        end
        default: begin
          state_n = S_IDLE;
          step_n  = '0;
          ph_n    = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    led_l_n = '0;
    led_r_n = '0;
    case (state_n)
      S_LEFT:  led_l_n = therm(step_n);
      S_RIGHT: led_r_n = therm(step_n);
      S_HAZ: begin
        led_l_n = {LAMPS{ph_n}};
        led_r_n = {LAMPS{ph_n}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge Rn) begin
    if (!Rn) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
      hz_s1 <= 1'b0;
      hz_s2 <= 1'b0;
      cnt   <= '0;
      state <= S_IDLE;
      step  <= '0;
      ph    <= 1'b0;
      led_l <= '0;
      led_r <= '0;
    end else begin
      sw_s1 <= SW;
      sw_s2 <= sw_s1;
      hz_s1 <= hazard;
      hz_s2 <= hz_s1;
      cnt   <= tick ? '0 : cnt + CW'(1);
      if (tick) begin
        state <= state_n;
        step  <= step_n;
        ph    <= ph_n;
        led_l <= led_l_n;
        led_r <= led_r_n;
      end
    end
  end

  assign CurrentState = state;
  assign LEDR_L       = led_l;
  assign LEDR_R       = led_r;

`ifdef TURN_SEQ_HEX_STATUS_EN
  logic [7:0] hex_q;

  function automatic logic [7:0] hex_of(input state_t s);
    logic [7:0] h;
    case (s)
      S_LEFT:  h = 8'hC7;
      S_RIGHT: h = 8'hAF;
      S_HAZ:   h = 8'h89;
      default: h = 8'hBF;
    endcase
    return h;
  endfunction

  always_ff @(posedge clk or negedge Rn) begin
    if (!Rn)       hex_q <= 8'hBF;
    else if (tick) hex_q <= hex_of(state_n);
  end

  assign HEX0 = hex_q;
`else
  assign HEX0 = 8'hFF;
`endif

endmodule

// File: tb/tb_turn_seq.sv
// Bench for turn_seq: a default instance (LAMPS=3, DIV=4) and an edge
// instance (LAMPS=1, DIV=1) share stimulus and are checked against a model.
module tb_turn_seq;

  logic       clk;
  logic       rst_n;
  logic [1:0] sw;
  logic       hazard;

  logic [2:0] st_a, st_b;
  logic [2:0] l_a, r_a;
  logic [0:0] l_b, r_b;
  logic [7:0] hex_a, hex_b;

  int checks = 0;
  int errors = 0;

  turn_seq #(.LAMPS(3), .DIV(4)) u_dut (
    .clk(clk), .Rn(rst_n), .SW(sw), .hazard(hazard),
    .CurrentState(st_a), .LEDR_L(l_a), .LEDR_R(r_a), .HEX0(hex_a)
  );

  turn_seq #(.LAMPS(1), .DIV(1)) u_edge (
    .clk(clk), .Rn(rst_n), .SW(sw), .hazard(hazard),
    .CurrentState(st_b), .LEDR_L(l_b), .LEDR_R(r_b), .HEX0(hex_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural reference, index 0 = default instance, 1 = edge instance
  int lamps_p[2] = '{3, 1};
  int div_p[2]   = '{4, 1};
  int m_mode[2], m_step[2], m_ph[2], m_cnt[2], m_d1[2], m_d2[2];

  function automatic int hex_of(input int mode);
`ifdef TURN_SEQ_HEX_STATUS_EN
    case (mode)
      1: return 8'hC7;
      2: return 8'hAF;
      3: return 8'h89;
      default: return 8'hBF;
    endcase
`else
    return (mode >= 0) ? 8'hFF : 8'hFF;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_step[i] = 0; m_ph[i] = 0;
      m_cnt[i] = 0;  m_d1[i] = 0;   m_d2[i] = 0;
    end
  endtask

  // request code matches the mode numbering: 0 none, 1 left, 2 right, 3 hazard
  function automatic int decode(input int raw);
    int l, r, h;
    l = raw & 1; r = (raw >> 1) & 1; h = (raw >> 2) & 1;
    if (h == 1 || (l == 1 && r == 1)) return 3;
    if (l == 1) return 1;
    if (r == 1) return 2;
    return 0;
  endfunction

  task automatic model_update(input int i);
    int req;
    bit tk;
    if (!rst_n) begin
      m_mode[i] = 0; m_step[i] = 0; m_ph[i] = 0;
      m_cnt[i] = 0;  m_d1[i] = 0;   m_d2[i] = 0;
      return;
    end
    req = decode(m_d2[i]);
    tk = (m_cnt[i] == div_p[i] - 1);
    m_cnt[i] = (m_cnt[i] + 1) % div_p[i];
    m_d2[i] = m_d1[i];
    m_d1[i] = {29'd0, hazard, sw};
    if (!tk) return;
    if (m_mode[i] == 0) begin
      if (req != 0) begin m_mode[i] = req; m_step[i] = 0; m_ph[i] = 0; end
    end else if (m_mode[i] == 3) begin
      if (req == 3) m_ph[i] = 1 - m_ph[i];
      else if (m_ph[i] == 1) m_ph[i] = 0;
      else begin m_mode[i] = req; m_step[i] = 0; end
    end else begin
      if (req == 3) begin m_mode[i] = 3; m_step[i] = 0; m_ph[i] = 0; end
      else if (m_step[i] == lamps_p[i]) begin m_mode[i] = req; m_step[i] = 0; end
      else m_step[i] = m_step[i] + 1;
    end
  endtask

  function automatic int exp_led(input int i, input int side);
    if ((m_mode[i] == 1 && side == 0) || (m_mode[i] == 2 && side == 1))
      return (1 << m_step[i]) - 1;
    if (m_mode[i] == 3 && m_ph[i] == 1) return (1 << lamps_p[i]) - 1;
    return 0;
  endfunction

  // scoreboard
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("a_state", int'(st_a), m_mode[0]);
    check("a_led_l", int'(l_a), exp_led(0, 0));
    check("a_led_r", int'(r_a), exp_led(0, 1));
    check("a_hex", int'(hex_a), hex_of(m_mode[0]));
    check("b_state", int'(st_b), m_mode[1]);
    check("b_led_l", int'(l_b), exp_led(1, 0));
    check("b_led_r", int'(r_b), exp_led(1, 1));
    check("b_hex", int'(hex_b), hex_of(m_mode[1]));
  endtask

  // driver: inputs change at negedge, model steps at posedge, compare at negedge
  task automatic cycle();
    @(posedge clk);
    model_update(0);
    model_update(1);
    @(negedge clk);
    check_model();
  endtask

  task automatic async_reset_check(input string tag);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check({tag, "_state"}, int'(st_a), 0);
    check({tag, "_leds"}, int'({l_a, r_a}), 0);
    check({tag, "_hex"}, int'(hex_a), hex_of(0));
    check({tag, "_b_leds"}, int'({l_b, r_b}), 0);
  endtask

  typedef struct {
    logic [1:0] sw;
    logic       hz;
    int         cyc;
    int         st;
    int         l;
    int         r;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{2'b01, 1'b0, 4, 1, 3'b000, 3'b000};
    tbl[1]  = '{2'b01, 1'b0, 4, 1, 3'b001, 3'b000};
    tbl[2]  = '{2'b01, 1'b0, 4, 1, 3'b011, 3'b000};
    tbl[3]  = '{2'b00, 1'b0, 4, 1, 3'b111, 3'b000};
    tbl[4]  = '{2'b00, 1'b0, 4, 0, 3'b000, 3'b000};
    tbl[5]  = '{2'b00, 1'b1, 4, 3, 3'b000, 3'b000};
    tbl[6]  = '{2'b00, 1'b1, 4, 3, 3'b111, 3'b111};
    tbl[7]  = '{2'b00, 1'b0, 4, 3, 3'b000, 3'b000};
    tbl[8]  = '{2'b10, 1'b0, 4, 2, 3'b000, 3'b000};
    tbl[9]  = '{2'b10, 1'b0, 4, 2, 3'b000, 3'b001};
    tbl[10] = '{2'b10, 1'b1, 4, 3, 3'b000, 3'b000};
    tbl[11] = '{2'b11, 1'b0, 4, 3, 3'b111, 3'b111};
    tbl[12] = '{2'b00, 1'b0, 4, 3, 3'b000, 3'b000};
    tbl[13] = '{2'b00, 1'b0, 4, 0, 3'b000, 3'b000};

    sw = 2'b00;
    hazard = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    repeat (3) cycle();
    check("reset_state", int'(st_a), 0);
    check("reset_leds", int'({l_a, r_a}), 0);
    check("reset_hex", int'(hex_a), hex_of(0));
    rst_n = 1'b1;

    // directed sweep / hazard table against fixed expectations
    for (int v = 0; v < 14; v++) begin
      sw = tbl[v].sw;
      hazard = tbl[v].hz;
      repeat (tbl[v].cyc) cycle();
      check($sformatf("tbl%0d_state", v), int'(st_a), tbl[v].st);
      check($sformatf("tbl%0d_led_l", v), int'(l_a), tbl[v].l);
      check($sformatf("tbl%0d_led_r", v), int'(r_a), tbl[v].r);
      check($sformatf("tbl%0d_hex", v), int'(hex_a), hex_of(tbl[v].st));
    end

    // asynchronous reset in the middle of a left sweep
    sw = 2'b01;
    repeat (14) cycle();
    check("pre_reset_busy", int'(st_a), 1);
    async_reset_check("async_rst");
    repeat (3) cycle();
    sw = 2'b00;
    rst_n = 1'b1;

    // edge instance: one lamp toggling every cycle under a left request
    sw = 2'b01;
    repeat (3) cycle();
    check("edge_enter", int'(st_b), 1);
    check("edge_led0", int'(l_b), 0);
    for (int k = 0; k < 6; k++) begin
      cycle();
      check($sformatf("edge_toggle%0d", k), int'(l_b), (k % 2 == 0) ? 1 : 0);
      check($sformatf("edge_hex%0d", k), int'(hex_b), hex_of(1));
    end

    // randomized segments against the reference model
    for (int s = 0; s < 120; s++) begin
      sw = 2'($urandom_range(0, 3));
      hazard = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 30) == 0) begin
        async_reset_check($sformatf("rand_rst%0d", s));
        repeat (2) cycle();
        rst_n = 1'b1;
      end
      repeat ($urandom_range(1, 24)) cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
